// File: rtl/jtag_dr_controller.sv
// JTAG data-register controller: IDCODE, USER, ABORT and BYPASS chains behind a TAP.
// Define JTAG_USER_REG_EN to build the USER chain and user_reg; otherwise USER decodes as BYPASS.
module jtag_dr_controller #(
  parameter logic [31:0] IDCODE_VALUE = 32'h000FAF01,
  parameter int          USER_WIDTH   = 8
) (
  input  logic                  tck,
  input  logic                  trst_n,
  input  logic [3:0]            ir,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic [USER_WIDTH-1:0] user_reg,
  output logic                  user_update,
  output logic                  abort_req,
  output logic [5:0]            bit_count
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LOADED   = 2'd1;
  localparam logic [1:0] ST_SHIFTING = 2'd2;

  localparam logic [1:0] SEL_IDCODE = 2'd0;
  localparam logic [1:0] SEL_USER   = 2'd1;
  localparam logic [1:0] SEL_ABORT  = 2'd2;
  localparam logic [1:0] SEL_BYPASS = 2'd3;

  logic [1:0]  state;
  logic [1:0]  sel;
  logic [1:0]  decoded_sel;
  logic [31:0] idcode_chain;
  logic        bypass_bit;
  logic        chain_lsb;
  logic        do_capture;
  logic        do_shift;
  logic        do_update;
  logic        commit;

  always_comb begin
    decoded_sel = SEL_BYPASS;
    case (ir)
      4'b1110: decoded_sel = SEL_IDCODE;
      4'b1000: decoded_sel = SEL_ABORT;
`ifdef JTAG_USER_REG_EN
      4'b0100: decoded_sel = SEL_USER;
`endif
      default: decoded_sel = SEL_BYPASS;
    endcase
  end

  // Strobe priority: capture beats shift beats update; only one acts per cycle.
  assign do_capture = capture_dr;
  assign do_shift   = shift_dr & ~capture_dr;
  assign do_update  = update_dr & ~capture_dr & ~shift_dr;
  assign commit     = do_update & (state != ST_IDLE);

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state     <= ST_IDLE;
      sel       <= SEL_IDCODE;
      bit_count <= 6'd0;
    end else if (do_capture) begin
      state     <= ST_LOADED;
      sel       <= decoded_sel;
      bit_count <= 6'd0;
    end else if (do_shift) begin
      if (state == ST_LOADED) begin
        state <= ST_SHIFTING;
      end
      if (bit_count != 6'd63) begin
        bit_count <= bit_count + 6'd1;
      end
    end else if (commit) begin
      state <= ST_IDLE;
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      idcode_chain <= 32'd0;
      bypass_bit   <= 1'b0;
    end else if (do_capture) begin
      idcode_chain <= IDCODE_VALUE;
      bypass_bit   <= 1'b0;
    end else if (do_shift) begin
      if (sel == SEL_IDCODE) begin
        idcode_chain <= {tdi, idcode_chain[31:1]};
      end
      if ((sel == SEL_ABORT) || (sel == SEL_BYPASS)) begin
        bypass_bit <= tdi;
      end
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      abort_req <= 1'b0;
    end else begin
      abort_req <= commit && (sel == SEL_ABORT);
    end
  end

`ifdef JTAG_USER_REG_EN
  logic [USER_WIDTH-1:0] user_chain;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      user_chain  <= '0;
      user_reg    <= '0;
      user_update <= 1'b0;
    end else begin
      user_update <= commit && (sel == SEL_USER);
      if (do_capture) begin
        user_chain <= user_reg;
      end else if (do_shift && (sel == SEL_USER)) begin
        user_chain <= {tdi, user_chain[USER_WIDTH-1:1]};
      end
      if (commit && (sel == SEL_USER)) begin
        user_reg <= user_chain;
      end
    end
  end
`else
  assign user_reg    = '0;
  assign user_update = 1'b0;
`endif

  // ABORT and BYPASS share the single bypass flop.
  always_comb begin
    chain_lsb = bypass_bit;
    case (sel)
      SEL_IDCODE: chain_lsb = idcode_chain[0];
`ifdef JTAG_USER_REG_EN
      SEL_USER:   chain_lsb = user_chain[0];
`else
      SEL_USER:   chain_lsb = bypass_bit;
`endif
      default:    chain_lsb = bypass_bit;
    endcase
  end

  assign tdo_en = shift_dr;
  assign tdo    = tdo_en & chain_lsb;

endmodule

// File: tb/tb_jtag_dr_controller.sv
// Self-checking bench for jtag_dr_controller; tdo expectations flow through a scoreboard queue.
module tb_jtag_dr_controller;

  localparam logic [31:0] IDCODE = 32'h000FAF01;
  localparam int          UW     = 8;
`ifdef JTAG_USER_REG_EN
  localparam bit USER_EN = 1'b1;
`else
  localparam bit USER_EN = 1'b0;
`endif

  logic          tck;
  logic          trst_n;
  logic [3:0]    ir;
  logic          capture_dr;
  logic          shift_dr;
  logic          update_dr;
  logic          tdi;
  logic          tdo;
  logic          tdo_en;
  logic [UW-1:0] user_reg;
  logic          user_update;
  logic          abort_req;
  logic [5:0]    bit_count;

  int   checks   = 0;
  int   failures = 0;
  logic tdo_q[$];

  logic [31:0]   id_v;
  logic [UW-1:0] a5_v;
  logic [UW-1:0] ureg_exp;
  logic          e;

  jtag_dr_controller #(.IDCODE_VALUE(IDCODE), .USER_WIDTH(UW)) dut (
    .tck(tck), .trst_n(trst_n), .ir(ir), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .update_dr(update_dr), .tdi(tdi), .tdo(tdo),
    .tdo_en(tdo_en), .user_reg(user_reg), .user_update(user_update),
    .abort_req(abort_req), .bit_count(bit_count)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of strobes at the falling edge; the expected tdo is queued and checked before the rising edge.
  task apply_stimulus(input logic cap, input logic sh, input logic upd, input logic t,
                      input logic chk, input logic exp_tdo);
    logic got;
    @(negedge tck);
    capture_dr = cap;
    shift_dr   = sh;
    update_dr  = upd;
    tdi        = t;
    if (chk) tdo_q.push_back(exp_tdo);
    #1;
    if (chk) begin
      got = tdo_q.pop_front();
      check_output("tdo", tdo, got);
      check_output("tdo_en", tdo_en, sh);
    end
    @(posedge tck);
    #1;
  endtask

  task check_pulses(input string tag, input logic uu, input logic ab);
    check_output({tag, "_user_update"}, user_update, uu);
    check_output({tag, "_abort_req"}, abort_req, ab);
  endtask

  initial begin
    id_v = IDCODE;
    a5_v = 8'hA5;
    trst_n = 1'b0; ir = 4'b0000; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; tdi = 1'b0;
    #1;
    check_output("rst_tdo", tdo, 0);
    check_output("rst_tdo_en", tdo_en, 0);
    check_output("rst_user_reg", user_reg, 0);
    check_output("rst_bit_count", bit_count, 0);
    check_pulses("rst", 0, 0);
    repeat (2) @(negedge tck);
    trst_n = 1'b1;
    @(posedge tck); #1;
    check_output("post_rst_bit_count", bit_count, 0);

    // Update with no prior capture does nothing.
    apply_stimulus(0, 0, 1, 0, 0, 0);
    check_pulses("upd_idle", 0, 0);
    check_output("upd_idle_user_reg", user_reg, 0);

    // IDCODE readout, then recirculation and bit_count saturation.
    ir = 4'b1110;
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("idc_cap_count", bit_count, 0);
    for (int i = 0; i < 32; i++) apply_stimulus(0, 1, 0, 0, 1, id_v[i]);
    check_output("idc_count32", bit_count, 32);
    for (int i = 0; i < 40; i++) apply_stimulus(0, 1, 0, 1, 1, (i >= 32));
    check_output("idc_count_sat", bit_count, 63);

    // BYPASS one-cycle delay.
    ir = 4'b1111;
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 1, 1, 0);
    apply_stimulus(0, 1, 0, 0, 1, 1);
    apply_stimulus(0, 1, 0, 1, 1, 0);
    apply_stimulus(0, 1, 0, 1, 1, 1);
    check_output("byp_count", bit_count, 4);
    apply_stimulus(0, 0, 1, 0, 0, 0);
    check_pulses("byp_upd", 0, 0);

    // USER write of 8'hA5 (BYPASS behaviour when the USER register is not built).
    ir = 4'b0100;
    apply_stimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      apply_stimulus(0, 1, 0, a5_v[i], 1, USER_EN ? 1'b0 : ((i == 0) ? 1'b0 : a5_v[i-1]));
    apply_stimulus(0, 0, 1, 0, 0, 0);
    ureg_exp = USER_EN ? 8'hA5 : 8'h00;
    check_output("usr_user_reg", user_reg, ureg_exp);
    check_pulses("usr_upd", USER_EN, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_pulses("usr_after", 0, 0);
    apply_stimulus(0, 0, 1, 0, 0, 0);
    check_pulses("usr_upd_idle", 0, 0);
    check_output("usr_upd_idle_reg", user_reg, ureg_exp);

    // USER readback returns the committed value.
    apply_stimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 1, 0, 0, 1, ureg_exp[i]);

    // ABORT commit pulse.
    ir = 4'b1000;
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0, 0);
    check_pulses("abort_upd", 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_pulses("abort_after", 0, 0);

    // Strobe priority.
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0, 0);
    check_pulses("prio_cap_upd", 0, 0);
    check_output("prio_cap_count", bit_count, 0);
    apply_stimulus(0, 1, 1, 1, 1, 0);
    check_pulses("prio_sh_upd", 0, 0);
    check_output("prio_sh_count", bit_count, 1);
    apply_stimulus(0, 0, 1, 0, 0, 0);
    check_pulses("prio_upd", 0, 1);

    // ir changes after capture have no effect on the selected chain.
    ir = 4'b1110;
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1, id_v[0]);
    ir = 4'b1111;
    for (int i = 1; i < 4; i++) apply_stimulus(0, 1, 0, 0, 1, id_v[i]);
    check_output("irchg_count", bit_count, 4);

    // Reset in the middle of a USER shift discards it.
    ir = 4'b0100;
    apply_stimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      apply_stimulus(0, 1, 0, 1, 1, USER_EN ? ureg_exp[i] : ((i == 0) ? 1'b0 : 1'b1));
    @(negedge tck);
    #2;
    trst_n = 1'b0;
    #1;
    check_output("midrst_user_reg", user_reg, 0);
    check_output("midrst_count", bit_count, 0);
    check_output("midrst_tdo", tdo, 0);
    check_pulses("midrst", 0, 0);
    shift_dr = 1'b0;
    @(negedge tck);
    trst_n = 1'b1;
    apply_stimulus(0, 0, 1, 0, 0, 0);
    check_output("midrst_upd_reg", user_reg, 0);
    check_pulses("midrst_upd", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
